// File: rtl/layer_seq_ctrl.sv
// Sequencer for one systolic layer: arbitrates inference/training requests
// (training has priority), runs the layer with a timeout, and walks weight rows.
module layer_seq_ctrl #(
    parameter int ROWS         = 30,
    parameter int TRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 160
) (
    input  logic                    clk,
    input  logic                    rst_overall_n,
    input  logic                    infer_req,
    input  logic                    train_req,
    output logic                    infer_done,
    output logic                    train_done,
    output logic                    timeout_err,
    output logic                    busy,
    output logic                    wrow_req,
    input  logic                    wrow_valid,
    input  logic                    layer_done,
    output logic                    layer_en,
    output logic                    layer_rst_vals,
    output logic                    layer_train_en,
    output logic [$clog2(ROWS)-1:0] layer_row_sel,
    output logic                    bias_gate
);

    localparam int RW    = $clog2(ROWS);
    localparam int CMAX  = (TIMEOUT > TRAIN_CYCLES) ? TIMEOUT : TRAIN_CYCLES;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_FIN,
        S_TREQ,
        S_TPULSE,
        S_TGAP,
        S_TDONE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tmo_d;

    logic            infer_done_d;
    logic            train_done_d;
    logic            timeout_err_d;
    logic            busy_d;
    logic            wrow_req_d;
    logic            layer_en_d;
    logic            layer_rst_vals_d;
    logic            layer_train_en_d;
    logic [RW-1:0]   layer_row_sel_d;
    logic            bias_gate_d;

    // cnt_q is shared: RUN timeout counter and T_PULSE width counter.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (train_req) begin
                    state_d = S_TREQ;
                    row_d   = '0;
                end else if (infer_req) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
            S_RUN: begin
                if (layer_done) begin
                    state_d = S_FIN;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_FIN;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            S_TREQ: begin
                if (wrow_valid) begin
                    state_d = S_TPULSE;
                    cnt_d   = '0;
                end
            end
            S_TPULSE: begin
                if (cnt_q == CW'(TRAIN_CYCLES - 1)) begin
                    state_d = S_TGAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_TGAP: begin
                if (row_q == RW'(ROWS - 1)) begin
                    state_d = S_TDONE;
                end else begin
                    row_d   = row_q + RW'(1);
                    state_d = S_TREQ;
                end
            end
            S_TDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_comb begin
        infer_done_d     = (state_d == S_FIN);
        train_done_d     = (state_d == S_TDONE);
        timeout_err_d    = tmo_d;
        busy_d           = (state_d != S_IDLE);
        wrow_req_d       = (state_d == S_TREQ);
        layer_en_d       = (state_d == S_RUN);
        layer_rst_vals_d = (state_d == S_CLR);
        layer_train_en_d = (state_d == S_TPULSE);
        // Bias updates land on every train_en rising edge, so only row 0 sees them.
        bias_gate_d      = (state_d == S_TPULSE) && (row_d == '0);
        layer_row_sel_d  = layer_row_sel;
        if (state_d == S_TREQ) begin
            layer_row_sel_d = row_d;
        end else if (state_d == S_TDONE) begin
            layer_row_sel_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state_q        <= S_IDLE;
            row_q          <= '0;
            cnt_q          <= '0;
            infer_done     <= 1'b0;
            train_done     <= 1'b0;
            timeout_err    <= 1'b0;
            busy           <= 1'b0;
            wrow_req       <= 1'b0;
            layer_en       <= 1'b0;
            layer_rst_vals <= 1'b0;
            layer_train_en <= 1'b0;
            layer_row_sel  <= '0;
            bias_gate      <= 1'b0;
        end else begin
            state_q        <= state_d;
            row_q          <= row_d;
            cnt_q          <= cnt_d;
            infer_done     <= infer_done_d;
            train_done     <= train_done_d;
            timeout_err    <= timeout_err_d;
            busy           <= busy_d;
            wrow_req       <= wrow_req_d;
            layer_en       <= layer_en_d;
            layer_rst_vals <= layer_rst_vals_d;
            layer_train_en <= layer_train_en_d;
            layer_row_sel  <= layer_row_sel_d;
            bias_gate      <= bias_gate_d;
        end
    end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: builds a per-cycle expected output timeline from the
// operation rules and replays it against the DUT, with random ignored-input noise.
module tb_layer_seq_ctrl;

    localparam int ROWS  = 30;
    localparam int TC    = 2;
    localparam int TO    = 160;
    localparam int RW    = $clog2(ROWS);
    localparam int OW    = RW + 9;
    localparam int B_BG  = RW;
    localparam int B_TEN = RW + 1;
    localparam int B_RV  = RW + 2;
    localparam int B_EN  = RW + 3;
    localparam int B_WRQ = RW + 4;
    localparam int B_TOE = RW + 6;
    localparam int B_TDN = RW + 7;
    localparam int B_IDN = RW + 8;

    logic          clk = 1'b0;
    logic          rst_overall_n = 1'b0;
    logic          infer_req = 1'b0;
    logic          train_req = 1'b0;
    logic          wrow_valid = 1'b0;
    logic          layer_done = 1'b0;
    logic          infer_done, train_done, timeout_err, busy, wrow_req;
    logic          layer_en, layer_rst_vals, layer_train_en, bias_gate;
    logic [RW-1:0] layer_row_sel;

    logic [OW-1:0] exp_q[$];
    logic [3:0]    in_q[$];
    int            dly[ROWS];
    int            mark_idx;
    bit            noise_en;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    layer_seq_ctrl #(.ROWS(ROWS), .TRAIN_CYCLES(TC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_overall_n(rst_overall_n),
        .infer_req(infer_req), .train_req(train_req),
        .infer_done(infer_done), .train_done(train_done),
        .timeout_err(timeout_err), .busy(busy), .wrow_req(wrow_req),
        .wrow_valid(wrow_valid), .layer_done(layer_done),
        .layer_en(layer_en), .layer_rst_vals(layer_rst_vals),
        .layer_train_en(layer_train_en), .layer_row_sel(layer_row_sel),
        .bias_gate(bias_gate)
    );

    wire [OW-1:0] dut_vec = {infer_done, train_done, timeout_err, busy, wrow_req,
                             layer_en, layer_rst_vals, layer_train_en, bias_gate,
                             layer_row_sel};

    function automatic logic [OW-1:0] mk(bit idn, bit tdn, bit toe, bit bsy, bit wrq,
                                         bit en, bit rv, bit ten, bit bg, int rs);
        logic [RW-1:0] r;
        r = RW'(rs);
        return {idn, tdn, toe, bsy, wrq, en, rv, ten, bg, r};
    endfunction

    // Inputs the DUT must ignore: random when noise is on, else quiet.
    function automatic bit nz();
        return noise_en ? bit'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Request level mid-operation: random when noise is on, else held.
    function automatic bit rq();
        return noise_en ? bit'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic push(logic [OW-1:0] o, bit ireq, bit treq, bit wval, bit ldone);
        exp_q.push_back(o);
        in_q.push_back({ireq, treq, wval, ldone});
    endtask

    task automatic add_idle(int n);
        repeat (n) push(mk(0,0,0,0,0,0,0,0,0,0), 1'b0, 1'b0, nz(), nz());
    endtask

    // lat = number of en-high cycles before the layer reports done; out of 1..TO means never.
    task automatic add_infer(int lat);
        bit tmo;
        int e;
        tmo = !(lat >= 1 && lat <= TO);
        e = tmo ? TO : lat;
        push(mk(0,0,0,0,0,0,0,0,0,0), 1'b1, 1'b0, nz(), nz());
        push(mk(0,0,0,1,0,0,1,0,0,0), rq(), 1'b0, nz(), nz());
        for (int k = 0; k < e; k++)
            push(mk(0,0,0,1,0,1,0,0,0,0), rq(), 1'b0, nz(), (!tmo && k == lat - 1));
        push(mk(1,0,tmo,1,0,0,0,0,0,0), rq(), 1'b0, nz(), nz());
    endtask

    // Row r waits dly[r] extra cycles for its weights.
    task automatic add_train(bit with_infer);
        push(mk(0,0,0,0,0,0,0,0,0,0), with_infer, 1'b1, nz(), nz());
        for (int r = 0; r < ROWS; r++) begin
            for (int j = 0; j <= dly[r]; j++)
                push(mk(0,0,0,1,1,0,0,0,0,r), with_infer ? 1'b1 : nz(), rq(), (j == dly[r]), nz());
            if (r == 12) mark_idx = exp_q.size();
            for (int p = 0; p < TC; p++)
                push(mk(0,0,0,1,0,0,0,1,(r == 0),r), with_infer ? 1'b1 : nz(), rq(), nz(), nz());
            push(mk(0,0,0,1,0,0,0,0,0,r), with_infer ? 1'b1 : nz(), rq(), nz(), nz());
        end
        push(mk(0,1,0,1,0,0,0,0,0,0), with_infer ? 1'b1 : nz(), rq(), nz(), nz());
    endtask

    function automatic int cnt_bit(int b);
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i][b]) c++;
        return c;
    endfunction

    function automatic int first_bit(int b);
        foreach (exp_q[i]) if (exp_q[i][b]) return i;
        return -1;
    endfunction

    function automatic int rises(int b);
        int c = 0;
        for (int i = 1; i < exp_q.size(); i++) if (exp_q[i][b] && !exp_q[i-1][b]) c++;
        return c;
    endfunction

    function automatic int cnt_req_row(int row);
        int c = 0;
        foreach (exp_q[i]) if (exp_q[i][B_WRQ] && exp_q[i][RW-1:0] == RW'(row)) c++;
        return c;
    endfunction

    task automatic check_vec(string name, int k, logic [OW-1:0] got, logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%b exp=%b (idn tdn toe bsy wrq en rv ten bg row)",
                     name, k, got, exp);
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Replays the timeline; abort_at >= 0 pulls reset mid-cycle at that index.
    task automatic play(string name, int abort_at);
        int k = 0;
        logic [OW-1:0] e;
        logic [3:0] iv;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            iv = in_q.pop_front();
            @(negedge clk);
            check_vec(name, k, dut_vec, e);
            {infer_req, train_req, wrow_valid, layer_done} = iv;
            if (k == abort_at) begin
                #1 rst_overall_n = 1'b0;
                #1 check_vec("reset_abort_same_cycle", k, dut_vec, '0);
                {infer_req, train_req, wrow_valid, layer_done} = 4'b0;
                repeat (2) @(negedge clk);
                check_vec("reset_abort_held", k, dut_vec, '0);
                rst_overall_n = 1'b1;
                exp_q.delete();
                in_q.delete();
                break;
            end
            k++;
        end
    endtask

    task automatic clear_dly();
        foreach (dly[r]) dly[r] = 0;
    endtask

    initial begin
        int kind;
        int lat;
        noise_en = 1'b0;
        clear_dly();

        // Reset state, with requests asserted during reset.
        infer_req = 1'b1;
        train_req = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("reset_state", 0, dut_vec, '0);
        infer_req = 1'b0;
        train_req = 1'b0;
        @(negedge clk);
        rst_overall_n = 1'b1;

        // Inference finishing after 110 en cycles.
        add_infer(110);
        add_idle(2);
        check_int("pin_infer_en_cycles", cnt_bit(B_EN), 110);
        check_int("pin_infer_rst_vals", cnt_bit(B_RV), 1);
        check_int("pin_infer_done_idx", first_bit(B_IDN), 112);
        check_int("pin_infer_no_timeout", cnt_bit(B_TOE), 0);
        play("infer_110", -1);

        // Inference timing out.
        add_infer(0);
        add_idle(2);
        check_int("pin_timeout_en_cycles", cnt_bit(B_EN), 160);
        check_int("pin_timeout_err_idx", first_bit(B_TOE), 162);
        check_int("pin_timeout_done_idx", first_bit(B_IDN), 162);
        play("infer_timeout", -1);

        // Training with weights always ready.
        add_train(1'b0);
        add_idle(2);
        check_int("pin_train_done_idx", first_bit(B_TDN), 121);
        check_int("pin_train_pulses", rises(B_TEN), 30);
        check_int("pin_train_en_cycles", cnt_bit(B_TEN), 60);
        check_int("pin_bias_gate_cycles", cnt_bit(B_BG), 2);
        play("train_plain", -1);

        // Row 3 weights arrive 7 cycles late.
        dly[3] = 7;
        add_train(1'b0);
        add_idle(2);
        check_int("pin_row3_req_cycles", cnt_req_row(3), 8);
        check_int("pin_delay_done_idx", first_bit(B_TDN), 128);
        play("train_row3_delay", -1);
        clear_dly();

        // Both requests together: training first, pending inference after.
        add_train(1'b1);
        add_infer(50);
        add_idle(2);
        check_int("pin_both_rst_after_done", first_bit(B_RV) - first_bit(B_TDN), 2);
        play("both_requests", -1);

        // Reset during the row-12 pulse.
        add_train(1'b0);
        play("train_abort", mark_idx + 1);
        add_idle(5);
        play("after_abort", -1);

        // Randomized operations with noise on ignored inputs.
        noise_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    case ($urandom_range(0, 5))
                        0: lat = 1;
                        1: lat = TO - 1;
                        2: lat = TO;
                        3: lat = TO + 1;
                        4: lat = 0;
                        default: lat = $urandom_range(1, TO);
                    endcase
                    add_infer(lat);
                end
                1, 2: begin
                    foreach (dly[r]) dly[r] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
                    add_train(kind == 2);
                    if (kind == 2) add_infer($urandom_range(1, TO));
                end
                default: add_idle($urandom_range(1, 6));
            endcase
            add_idle($urandom_range(0, 3));
            play("random", -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Controller that sequences one `layer` systolic array instance. It accepts inference and training requests from the network-level scheduler and arbitrates between them, giving training fixed priority. It drives the layer's `en`, `rst_vals`, `row_sel` and `train_en` controls. During training it walks every weight row, fetching each row from an external weight buffer. It also gates the bias-update bus so biases are applied exactly once per training pass.

## Interface
Parameters:
- `ROWS`, 30: rows of the controlled layer.
- `TRAIN_CYCLES`, 2: cycles `layer_train_en` is held high per row; legal range 1..15.
- `TIMEOUT`, 160: maximum cycles spent in RUN waiting for `layer_done`; must exceed the layer's latency of columns+10+ROWS+4.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_overall_n`  in  1  asynchronous, active-low reset.
- `infer_req`  in  1  inference request; held high until `infer_done`.
- `train_req`  in  1  training request; held high until `train_done`.
- `infer_done`  out  1  one-cycle pulse when inference completes or times out.
- `train_done`  out  1  one-cycle pulse when all rows are updated.
- `timeout_err`  out  1  one-cycle pulse, coincident with `infer_done`, on timeout.
- `busy`  out  1  high in every state except IDLE.
- `wrow_req`  out  1  requests weight row `layer_row_sel` from the weight buffer.
- `wrow_valid`  in  1  weight row is present on the layer's `weight_update` bus.
- `layer_done`  in  1  the layer's `done` output.
- `layer_en`  out  1  drives the layer's `en`.
- `layer_rst_vals`  out  1  drives the layer's `rst_vals`.
- `layer_train_en`  out  1  drives the layer's `train_en`.
- `layer_row_sel`  out  $clog2(ROWS)  drives the layer's `row_sel`.
- `bias_gate`  out  1  high enables the bias-update bus into the layer; low forces it to zero.

## Operation
- All outputs are registered.
- Reset value of every output is 0, and the state is IDLE.
- States: IDLE, CLR, RUN, FIN, T_REQ, T_PULSE, T_GAP, T_DONE.
- IDLE:
  - `train_req`=1 → T_REQ, with row counter r=0.
  - Otherwise `infer_req`=1 → CLR.
  - If both requests are high, training wins. `infer_req` stays pending and is served after `train_done`.
- CLR (1 cycle): `layer_rst_vals`=1 and `layer_en`=0. Next state is RUN, with the timeout counter cleared.
- RUN: `layer_en`=1 and the timeout counter increments every cycle.
  - `layer_done`=1 → FIN.
  - Counter reaches TIMEOUT-1 → FIN with `timeout_err`=1.
- FIN (1 cycle): `layer_en`=0 and `infer_done`=1, then IDLE.
- T_REQ: `wrow_req`=1 and `layer_row_sel`=r. Waits indefinitely for `wrow_valid`=1, then goes to T_PULSE. `wrow_req` drops on that transition.
- T_PULSE (exactly TRAIN_CYCLES cycles):
  - `layer_train_en`=1.
  - `bias_gate`=1 only when r==0, because the layer adds bias updates on every train_en rising edge.
  - `layer_row_sel` is held stable.
- T_GAP (1 cycle): `layer_train_en`=0, which guarantees a fresh rising edge for the next row.
  - If r==ROWS-1 → T_DONE.
  - Otherwise r=r+1 → T_REQ.
- T_DONE (1 cycle): `train_done`=1 and `layer_row_sel`=0, then IDLE.
- Dropping a request mid-operation is ignored; the operation runs to completion.
- A new request is sampled only in IDLE, so there is at least one IDLE cycle between operations.
- `layer_done` outside RUN is ignored. `wrow_valid` outside T_REQ is ignored.
- Asserting `rst_overall_n` low in any state immediately forces IDLE and zeroes all outputs, including a `layer_train_en` pulse in progress. No done pulse is issued for the aborted operation.

## Timing
- Cycle 0 is the first IDLE cycle with `infer_req`=1.
  - Cycle 1: `layer_rst_vals`=1.
  - Cycle 2 onward: `layer_en`=1.
  - `layer_done` seen at cycle N: `infer_done`=1 and `layer_en`=0 at cycle N+1.
- Timeout: `layer_en` is high for exactly TIMEOUT cycles, then `infer_done` and `timeout_err` pulse together.
- Training with `wrow_valid` tied high: each row takes 1+TRAIN_CYCLES+1 cycles.
  - Total from the first T_REQ cycle to `train_done` is ROWS·(TRAIN_CYCLES+2)+1 cycles.
  - With defaults: 121 cycles.
- `layer_row_sel` changes only on entry to T_REQ. It is never changed while `layer_train_en`=1.

## Test plan
- Reset then `infer_req`=1, with a layer model asserting `layer_done` 110 cycles after `en` rises → `rst_vals` is high for 1 cycle, `en` is high for 110 cycles, `infer_done` pulses once, and `timeout_err` stays 0.
- Inference with `layer_done` never asserted, TIMEOUT=160 → `en` is high for 160 cycles, then `infer_done` and `timeout_err` pulse in the same cycle, then IDLE.
- `train_req`, `wrow_valid`=1, ROWS=30, TRAIN_CYCLES=2 → 30 `train_en` pulses, each 2 cycles wide with a 1-cycle low gap. `row_sel` steps 0..29. `bias_gate` is high only during the row-0 pulse. `train_done` fires at cycle 121.
- `wrow_valid` delayed 7 cycles on row 3 → `wrow_req` is held 8 cycles with `row_sel`=3 and `train_en`=0 until valid. Other rows are unaffected.
- `infer_req` and `train_req` rise in the same cycle → training completes fully, then `rst_vals` pulses on the second cycle after `train_done`, and inference runs.
- `rst_overall_n` pulled low during row 12 T_PULSE → all outputs are 0 in the same cycle. After release the block is IDLE with `busy`=0, and no done pulse is issued.
